// File: rtl/parking_pkg.sv
// Shared definitions for the parking controller slice.
//   - door_state_e : state encoding shared by the gate and blink timers
//   - idx_width()  : width of a bay index, at least 1 bit
//   - cnt_width()  : width of a counter that can hold 0..n
//   - DEF_*        : default parameter values for the blocks below
package parking_pkg;

  localparam int DEF_NUM_SLOTS    = 4;
  localparam int DEF_DOOR_CYCLES  = 4;
  localparam int DEF_BLINK_CYCLES = 6;

  typedef enum logic {
    CLOSED = 1'b0,
    OPEN   = 1'b1
  } door_state_e;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/parking_door_timer.sv
// Restartable open/closed timer.
// After a trigger, open stays high for exactly CYCLES cycles. A trigger
// while already open reloads the count, so the window is always measured
// from the most recent trigger.
// Ports:
//   clk     in  rising-edge clock
//   reset   in  asynchronous active-low reset
//   trigger in  load the timer and open (single-cycle strobe)
//   open    out high while the FSM is in OPEN
module parking_door_timer
  import parking_pkg::*;
#(
  parameter int CYCLES = DEF_DOOR_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  output logic open
);

  localparam int TW = $clog2(CYCLES + 1);

  door_state_e   state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLOSED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (trigger) begin
      state_d = OPEN;
      cnt_d   = TW'(CYCLES);
    end else if (state_q == OPEN) begin
      cnt_d = cnt_q - TW'(1);
      // Close on the edge that consumes the last count, so OPEN lasts
      // exactly CYCLES cycles including the load cycle.
      if (cnt_q == TW'(1)) begin
        state_d = CLOSED;
      end
    end
  end

  assign open = (state_q == OPEN);

endmodule

// File: rtl/parking_controller_n.sv
// Parking lot controller for NUM_SLOTS bays.
// Allocates the lowest free bay on an entry edge, frees a chosen bay on an
// exit edge, keeps a free-bay count, times the gate and flags rejected
// entries (full_blink) and illegal exits (exit_error). All outputs are
// driven from flops.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   entry_sensor   level, car waiting at entry
//   exit_sensor    level, car waiting at exit
//   exit_slot      bay being vacated, sampled with the exit edge
//   occupied       per-bay occupancy bitmap
//   free_count     number of free bays
//   assigned_slot  bay granted by last accepted entry
//   assign_valid   1-cycle pulse on accepted entry
//   full           free_count == 0
//   door_open      gate open
//   full_blink     toggling rejection indicator
//   exit_error     1-cycle pulse on illegal exit
module parking_controller_n
  import parking_pkg::*;
#(
  parameter int  NUM_SLOTS    = DEF_NUM_SLOTS,
  parameter int  DOOR_CYCLES  = DEF_DOOR_CYCLES,
  parameter int  BLINK_CYCLES = DEF_BLINK_CYCLES,
  localparam int IDX_W        = idx_width(NUM_SLOTS),
  localparam int CNT_W        = cnt_width(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entry_sensor,
  input  logic                 exit_sensor,
  input  logic [IDX_W-1:0]     exit_slot,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic [CNT_W-1:0]     free_count,
  output logic [IDX_W-1:0]     assigned_slot,
  output logic                 assign_valid,
  output logic                 full,
  output logic                 door_open,
  output logic                 full_blink,
  output logic                 exit_error
);

  localparam int PAD_W = 1 << IDX_W;

  // Lowest-index zero bit of the bitmap; only used when a free bay exists.
  function automatic logic [IDX_W-1:0] lowest_free(input logic [NUM_SLOTS-1:0] occ);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occ[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  logic                 entry_q, exit_q;
  logic [NUM_SLOTS-1:0] occupied_q, occupied_d;
  logic [CNT_W-1:0]     free_count_q, free_count_d;
  logic [IDX_W-1:0]     assigned_slot_q, assigned_slot_d;
  logic                 assign_valid_q, exit_error_q, full_q, blink_q;
  logic                 blink_q_d;
  logic                 entry_ev, exit_ev, entry_ok, exit_ok, reject;
  logic                 blink_active;
  logic [PAD_W-1:0]     occ_pad;
  logic [IDX_W-1:0]     alloc_idx;

  assign entry_ev  = entry_sensor & ~entry_q;
  assign exit_ev   = exit_sensor & ~exit_q;
  assign alloc_idx = lowest_free(occupied_q);

  // Zero-padded bitmap: an exit_slot beyond NUM_SLOTS-1 reads as a free
  // bay and is therefore rejected as an illegal exit.
  always_comb begin
    occ_pad                = '0;
    occ_pad[NUM_SLOTS-1:0] = occupied_q;
  end

  // Decisions use the pre-update bitmap and count, so a bay freed this
  // cycle cannot be handed out this cycle, and a full lot rejects entry
  // even alongside a valid exit.
  assign exit_ok  = exit_ev && occ_pad[exit_slot];
  assign entry_ok = entry_ev && (free_count_q != '0);
  assign reject   = entry_ev && !entry_ok;

  always_comb begin
    occupied_d      = occupied_q;
    free_count_d    = free_count_q;
    assigned_slot_d = assigned_slot_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (exit_ok && (exit_slot == IDX_W'(i))) occupied_d[i] = 1'b0;
      if (entry_ok && (alloc_idx == IDX_W'(i))) occupied_d[i] = 1'b1;
    end
    if (entry_ok) assigned_slot_d = alloc_idx;
    case ({entry_ok, exit_ok})
      2'b10:   free_count_d = free_count_q - CNT_W'(1);
      2'b01:   free_count_d = free_count_q + CNT_W'(1);
      default: free_count_d = free_count_q;
    endcase
    // Restart the blink pattern at 1 on a rejection; otherwise toggle while
    // the blink timer runs and rest at 0.
    if (reject)            blink_q_d = 1'b1;
    else if (blink_active) blink_q_d = ~blink_q;
    else                   blink_q_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_q         <= 1'b0;
      exit_q          <= 1'b0;
      occupied_q      <= '0;
      free_count_q    <= CNT_W'(NUM_SLOTS);
      assigned_slot_q <= '0;
      assign_valid_q  <= 1'b0;
      exit_error_q    <= 1'b0;
      full_q          <= 1'b0;
      blink_q         <= 1'b0;
    end else begin
      entry_q         <= entry_sensor;
      exit_q          <= exit_sensor;
      occupied_q      <= occupied_d;
      free_count_q    <= free_count_d;
      assigned_slot_q <= assigned_slot_d;
      assign_valid_q  <= entry_ok;
      exit_error_q    <= exit_ev && !exit_ok;
      full_q          <= (free_count_d == '0);
      blink_q         <= blink_q_d;
    end
  end

  parking_door_timer #(.CYCLES(DOOR_CYCLES)) u_door (
    .clk     (clk),
    .reset   (reset),
    .trigger (entry_ok | exit_ok),
    .open    (door_open)
  );

  parking_door_timer #(.CYCLES(BLINK_CYCLES)) u_blink (
    .clk     (clk),
    .reset   (reset),
    .trigger (reject),
    .open    (blink_active)
  );

  assign occupied      = occupied_q;
  assign free_count    = free_count_q;
  assign assigned_slot = assigned_slot_q;
  assign assign_valid  = assign_valid_q;
  assign full          = full_q;
  assign exit_error    = exit_error_q;
  // Both terms are flops; gating by the timer keeps the pattern 0 once the
  // blink window has ended.
  assign full_blink    = blink_q & blink_active;

endmodule

// File: tb/tb_parking_controller_n.sv
// Directed bench for parking_controller_n (4 bays, door 3, blink 4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_parking_controller_n;

  logic       clk;
  logic       reset;
  logic       entry_sensor, exit_sensor;
  logic [1:0] exit_slot;
  logic [3:0] occupied;
  logic [2:0] free_count;
  logic [1:0] assigned_slot;
  logic       assign_valid, full, door_open, full_blink, exit_error;

  int checks = 0;
  int errors = 0;

  parking_controller_n #(
    .NUM_SLOTS    (4),
    .DOOR_CYCLES  (3),
    .BLINK_CYCLES (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .entry_sensor  (entry_sensor),
    .exit_sensor   (exit_sensor),
    .exit_slot     (exit_slot),
    .occupied      (occupied),
    .free_count    (free_count),
    .assigned_slot (assigned_slot),
    .assign_valid  (assign_valid),
    .full          (full),
    .door_open     (door_open),
    .full_blink    (full_blink),
    .exit_error    (exit_error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0; entry_sensor = 1'b0; exit_sensor = 1'b0; exit_slot = 2'd0;
    tick(2);
    checks++;
    if ({occupied, free_count, assigned_slot, assign_valid, full, door_open, full_blink, exit_error}
        !== {4'b0000, 3'd4, 2'd0, 5'b00000}) begin
      errors++;
      $display("FAIL reset_state got occ=%b free=%0d slot=%0d av=%b full=%b door=%b blink=%b err=%b",
               occupied, free_count, assigned_slot, assign_valid, full, door_open, full_blink, exit_error);
    end
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_fill;
    for (int i = 0; i < 4; i++) begin
      entry_sensor = 1'b1; tick(1); entry_sensor = 1'b0;
      checks++;
      if ({assign_valid, assigned_slot} !== {1'b1, 2'(i)}) begin
        errors++;
        $display("FAIL fill_grant[%0d] got av=%b slot=%0d exp av=1 slot=%0d", i, assign_valid, assigned_slot, i);
      end
      checks++;
      if ({free_count, full} !== {3'(3 - i), (i == 3)}) begin
        errors++;
        $display("FAIL fill_count[%0d] got free=%0d full=%b exp free=%0d full=%b", i, free_count, full, 3 - i, i == 3);
      end
      tick(1);
      checks++;
      if (assign_valid !== 1'b0) begin
        errors++;
        $display("FAIL fill_pulse[%0d] got av=%b exp 0", i, assign_valid);
      end
    end
    checks++;
    if (occupied !== 4'b1111) begin
      errors++;
      $display("FAIL fill_bitmap got %b exp 1111", occupied);
    end
    tick(4);
  endtask

  task automatic test_reject;
    logic [4:0] pat;
    pat = 5'b10100;
    entry_sensor = 1'b1; tick(1); entry_sensor = 1'b0;
    checks++;
    if ({occupied, free_count, assign_valid} !== {4'b1111, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reject_state got occ=%b free=%0d av=%b exp 1111/0/0", occupied, free_count, assign_valid);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({full_blink, door_open} !== {pat[4-k], 1'b0}) begin
        errors++;
        $display("FAIL reject_blink[%0d] got blink=%b door=%b exp blink=%b door=0", k, full_blink, door_open, pat[4-k]);
      end
      tick(1);
    end
  endtask

  task automatic test_exit;
    exit_slot = 2'd1; exit_sensor = 1'b1; tick(1); exit_sensor = 1'b0;
    checks++;
    if ({occupied, free_count, full, exit_error} !== {4'b1101, 3'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL exit_state got occ=%b free=%0d full=%b err=%b exp 1101/1/0/0", occupied, free_count, full, exit_error);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (door_open !== (k < 3)) begin
        errors++;
        $display("FAIL exit_door[%0d] got %b exp %b", k, door_open, k < 3);
      end
      tick(1);
    end
    entry_sensor = 1'b1; tick(1); entry_sensor = 1'b0;
    checks++;
    if ({assign_valid, assigned_slot, occupied, free_count} !== {1'b1, 2'd1, 4'b1111, 3'd0}) begin
      errors++;
      $display("FAIL exit_reuse got av=%b slot=%0d occ=%b free=%0d exp 1/1/1111/0", assign_valid, assigned_slot, occupied, free_count);
    end
    tick(5);
  endtask

  task automatic test_bad_exit;
    int grants;
    exit_slot = 2'd3; exit_sensor = 1'b1; tick(1); exit_sensor = 1'b0; tick(1);
    exit_slot = 2'd2; exit_sensor = 1'b1; tick(1); exit_sensor = 1'b0; tick(5);
    checks++;
    if ({occupied, free_count, door_open} !== {4'b0011, 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL bad_exit_setup got occ=%b free=%0d door=%b exp 0011/2/0", occupied, free_count, door_open);
    end
    exit_slot = 2'd2; exit_sensor = 1'b1; tick(1); exit_sensor = 1'b0;
    checks++;
    if ({exit_error, occupied, free_count, door_open} !== {1'b1, 4'b0011, 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL bad_exit got err=%b occ=%b free=%0d door=%b exp 1/0011/2/0", exit_error, occupied, free_count, door_open);
    end
    tick(1);
    checks++;
    if ({exit_error, door_open} !== 2'b00) begin
      errors++;
      $display("FAIL bad_exit_pulse got err=%b door=%b exp 0/0", exit_error, door_open);
    end
    grants = 0;
    entry_sensor = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (assign_valid) grants++;
    end
    entry_sensor = 1'b0;
    checks++;
    if ({grants == 1, occupied, free_count, assigned_slot} !== {1'b1, 4'b0111, 3'd1, 2'd2}) begin
      errors++;
      $display("FAIL held_entry got grants=%0d occ=%b free=%0d slot=%0d exp 1/0111/1/2", grants, occupied, free_count, assigned_slot);
    end
    tick(5);
  endtask

  task automatic test_simultaneous;
    entry_sensor = 1'b1; exit_sensor = 1'b1; exit_slot = 2'd0; tick(1);
    entry_sensor = 1'b0; exit_sensor = 1'b0;
    checks++;
    if ({assign_valid, assigned_slot, occupied, free_count, full} !== {1'b1, 2'd3, 4'b1110, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL simul_accept got av=%b slot=%0d occ=%b free=%0d full=%b exp 1/3/1110/1/0",
               assign_valid, assigned_slot, occupied, free_count, full);
    end
    tick(1);
    entry_sensor = 1'b1; tick(1); entry_sensor = 1'b0;
    checks++;
    if ({assigned_slot, occupied, free_count, full} !== {2'd0, 4'b1111, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL simul_refill got slot=%0d occ=%b free=%0d full=%b exp 0/1111/0/1", assigned_slot, occupied, free_count, full);
    end
    tick(5);
    entry_sensor = 1'b1; exit_sensor = 1'b1; exit_slot = 2'd0; tick(1);
    entry_sensor = 1'b0; exit_sensor = 1'b0;
    checks++;
    if ({assign_valid, full_blink, door_open, occupied, free_count, full} !== {3'b011, 4'b1110, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL simul_reject got av=%b blink=%b door=%b occ=%b free=%0d full=%b exp 0/1/1/1110/1/0",
               assign_valid, full_blink, door_open, occupied, free_count, full);
    end
    tick(6);
  endtask

  task automatic test_back_to_back;
    int opens;
    opens = 0;
    entry_sensor = 1'b1; tick(1); entry_sensor = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (door_open) opens++;
      if (k == 1) begin exit_slot = 2'd1; exit_sensor = 1'b1; end
      if (k == 2) exit_sensor = 1'b0;
      tick(1);
    end
    checks++;
    if ({opens == 5, door_open, occupied, free_count} !== {2'b10, 4'b1101, 3'd1}) begin
      errors++;
      $display("FAIL door_restart got opens=%0d door=%b occ=%b free=%0d exp 5/0/1101/1", opens, door_open, occupied, free_count);
    end
    entry_sensor = 1'b1; tick(1); entry_sensor = 1'b0;
    checks++;
    if ({door_open, assign_valid, assigned_slot, full} !== {2'b11, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset got door=%b av=%b slot=%0d full=%b exp 1/1/1/1", door_open, assign_valid, assigned_slot, full);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({occupied, free_count, assigned_slot, assign_valid, full, door_open, full_blink, exit_error}
        !== {4'b0000, 3'd4, 2'd0, 5'b00000}) begin
      errors++;
      $display("FAIL async_reset got occ=%b free=%0d slot=%0d av=%b full=%b door=%b blink=%b err=%b",
               occupied, free_count, assigned_slot, assign_valid, full, door_open, full_blink, exit_error);
    end
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_reject();
    test_exit();
    test_bad_exit();
    test_simultaneous();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_controller_n.md
Name: parking_controller_n

Overview:
- Parametrised next-generation parking controller for NUM_SLOTS bays.
- Tracks per-bay occupancy as a bitmap and allocates the lowest free bay on entry.
- Frees a driver-selected bay on exit, keeps a free-bay counter, and times the gate.
- Flags full and bad exits; sits between the sensor/switch front end and the display/gate drivers.

Parameters:
- NUM_SLOTS, 4, number of bays (2..64).
- DOOR_CYCLES, 4, cycles the gate stays open after an accepted event (>=1).
- BLINK_CYCLES, 6, cycles the full_blink output toggles after a rejected entry (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- entry_sensor  in  1  level; a car is waiting at the entry.
- exit_sensor  in  1  level; a car is waiting at the exit.
- exit_slot  in  IDX_W  bay being vacated, sampled with the exit event; IDX_W = max(1, clog2(NUM_SLOTS)).
- occupied  out  NUM_SLOTS  per-bay occupancy bitmap.
- free_count  out  CNT_W  number of free bays; CNT_W = clog2(NUM_SLOTS+1).
- assigned_slot  out  IDX_W  bay granted by the last accepted entry.
- assign_valid  out  1  one-cycle pulse when an entry is accepted.
- full  out  1  high while free_count == 0.
- door_open  out  1  gate open.
- full_blink  out  1  rejection indicator.
- exit_error  out  1  one-cycle pulse on an illegal exit.

Behaviour:
- Reset (asynchronous, reset=0) sets:
  - occupied=0, free_count=NUM_SLOTS, assigned_slot=0;
  - assign_valid=0, full=0, door_open=0, full_blink=0, exit_error=0;
  - door and blink timers cleared; internal sensor history regs cleared.
  - Reset mid-operation aborts any open or blink sequence immediately.
- Event detection:
  - Each sensor is registered once.
  - entry_ev = entry_sensor & ~entry_q; exit_ev likewise.
  - A sensor held high produces exactly one event.
  - All state updates on the same clk edge that samples the rising level, so outputs change 1 cycle after the sensor rises.
- Entry, when entry_ev fires:
  - If free_count > 0: set the lowest-index zero bit of occupied, assigned_slot <= that index, assign_valid pulses 1 cycle, door timer loads DOOR_CYCLES.
  - If free_count == 0: no bitmap change, blink timer loads BLINK_CYCLES.
- Exit, when exit_ev fires:
  - If exit_slot < NUM_SLOTS and occupied[exit_slot]==1: clear the bit, and door timer loads DOOR_CYCLES.
  - Otherwise exit_error pulses 1 cycle, with no state change and no door action.
- Simultaneous entry_ev and exit_ev:
  - Allocation uses the pre-update bitmap, so the bay being freed is not reusable in that cycle.
  - When full, the entry is still rejected even if a valid exit occurs in the same cycle.
  - A valid exit plus an accepted entry leaves free_count unchanged; each event alone gives ±1.
  - free_count never wraps below 0 or above NUM_SLOTS.
- Door FSM states: CLOSED, OPEN.
  - CLOSED->OPEN on any accepted event; the timer is loaded with DOOR_CYCLES.
  - In OPEN the timer decrements each cycle; OPEN->CLOSED when it reaches 0.
  - A new accepted event while OPEN reloads the timer (restartable).
  - door_open = (state==OPEN); it is high for exactly DOOR_CYCLES cycles after the last accepted event.
- Blink:
  - While the blink timer is nonzero, full_blink toggles every cycle starting at 1; otherwise it is 0.
  - A rejection during blinking reloads the timer and restarts the sequence at 1.
- full:
  - Registered and coherent with free_count; asserted in the same cycle free_count becomes 0.
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Shared package parking_pkg holds:
  - the door state enum {CLOSED, OPEN};
  - width helper functions for IDX_W and CNT_W;
  - default constants DEF_NUM_SLOTS=4, DEF_DOOR_CYCLES=4.
- One sub-module, parking_door_timer:
  - parameter CYCLES; inputs clk, reset, trigger; output open.
  - Restartable down-counter with the CLOSED/OPEN FSM.
  - The blink logic reuses it with CYCLES=BLINK_CYCLES, with a toggle flop added in the parent.
- The lowest-free-bay priority encoder stays as a function inside the top module.

Test Plan (NUM_SLOTS=4, DOOR_CYCLES=3, BLINK_CYCLES=4):
- Reset, then 4 separate entry pulses -> assigned_slot 0,1,2,3 with an assign_valid pulse each; free_count 4->3->2->1->0; full=1 after the 4th; occupied=4'b1111.
- Full lot, entry pulse -> occupied unchanged, door_open stays 0, full_blink = 1,0,1,0 then 0.
- Occupied=4'b1111, exit with exit_slot=1 -> occupied=4'b1101, free_count=1, full=0, door_open high for exactly 3 cycles; a following entry gets assigned_slot=1.
- Exit with exit_slot=2 while occupied=4'b0011 -> exit_error single pulse, no bitmap/count/door change; entry_sensor held high for 10 cycles -> exactly one allocation.
- Occupied=4'b0111, entry and exit (exit_slot=0) on the same edge -> entry gets slot 3, occupied=4'b1110, free_count stays 1.
  - Repeat with occupied=4'b1111 -> entry rejected (blink), slot 0 freed.
- Entry accepted, second accepted event 2 cycles later -> door_open continuous for 5 cycles total.
  - Then reset=0 mid-open -> all outputs return to reset values immediately, without waiting for a clock edge.
